uart_tx_sched: RTL and testbench

Two-requester scheduler for the shared UART transmitter. Requester S is the bus-slave TX FIFO and requester P is the protocol engine's response byte. The block picks one byte at a time and parks it in a holding register. It issues a single start pulse to `uart_tx` and waits out the handshake before the next pick. Arbitration is favoured-priority with a burst limit, so the non-favoured side cannot be starved.

---
 rtl/uart_tx_sched.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Schedules bytes from two requesters onto a single shared UART transmitter.
// The two requesters are:
//   S - the bus-slave TX FIFO
//   P - the protocol engine's response byte
//
// Each pick moves one byte into a holding register and issues one start pulse
// to uart_tx. The next pick waits until the handshake has been waited out.
//
// Arbitration favours one side (PREF_PROT). While the other side is waiting,
// the favoured side may win at most MAX_BURST times in a row; after that the
// other side gets a turn, so it can never be starved.
//
// Parameters
//   DATA_W     byte width (8 for the UART)
//   MAX_BURST  consecutive favoured grants allowed while the other side
//              waits (1..15)
//   PREF_PROT  0: S is favoured, 1: P is favoured
//
// Ports
//   i_clk         clock
//   i_reset       asynchronous active-high reset
//   i_slv_valid   S has a byte
//   i_slv_dat     S byte
//   o_slv_ready   S byte accepted this cycle (pop strobe)
//   i_prot_valid  P has a byte
//   i_prot_dat    P byte
//   o_prot_ready  P byte accepted this cycle
//   o_tx_dat      byte presented to uart_tx (the holding register)
//   o_tx_start    one-cycle start pulse to uart_tx
//   i_tx_ready    uart_tx idle
//   o_last_prot   source of the most recent grant (1 = P)
//   o_busy        scheduler is not idle
// -----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter bit PREF_PROT = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_slv_valid,
    input  logic [DATA_W-1:0] i_slv_dat,
    output logic              o_slv_ready,
    input  logic              i_prot_valid,
    input  logic [DATA_W-1:0] i_prot_dat,
    output logic              o_prot_ready,
    output logic [DATA_W-1:0] o_tx_dat,
    output logic              o_tx_start,
    input  logic              i_tx_ready,
    output logic              o_last_prot,
    output logic              o_busy
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
    localparam logic       PREF        = PREF_PROT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_SENT   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] hold;
    logic [3:0]        burst;
    logic              last_prot;

    logic fav_valid;
    logic oth_valid;
    logic any_valid;
    logic grant_fav;
    logic grant_prot;
    logic load;
    logic slv_ready;
    logic prot_ready;
    logic tx_start;

    // Counts favoured grants that happened while the other side waited.
    // Any other kind of grant restarts the count.
    // A grant at the limit always goes to the other side, so the increment
    // cannot pass BURST_LIMIT. The clamp only guards against reaching it
    // from an illegal start value.
    function automatic logic [3:0] next_burst(input logic       fav,
                                              input logic       oth_pending,
                                              input logic [3:0] cur);
        if (fav && oth_pending) begin
            if (cur >= BURST_LIMIT) begin
                return BURST_LIMIT;
            end
            return cur + 4'd1;
        end
        return 4'd0;
    endfunction

    // Arbitration. Only the IDLE branch of the FSM acts on this result.
    always_comb begin
        fav_valid = PREF ? i_prot_valid : i_slv_valid;
        oth_valid = PREF ? i_slv_valid  : i_prot_valid;
        any_valid = i_slv_valid | i_prot_valid;
        if (fav_valid && oth_valid) begin
            grant_fav = (burst != BURST_LIMIT);
        end else begin
            grant_fav = fav_valid;
        end
        grant_prot = grant_fav ? PREF : ~PREF;
    end

    // Next state and strobes.
    // The readies are masked by reset so a pop can never be signalled while
    // the holding register is being cleared.
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        slv_ready  = 1'b0;
        prot_ready = 1'b0;
        tx_start   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_valid && !i_reset) begin
                    load       = 1'b1;
                    prot_ready = grant_prot;
                    slv_ready  = ~grant_prot;
                    state_nxt  = ST_LOADED;
                end
            end
            ST_LOADED: begin
                tx_start = i_tx_ready;
                if (i_tx_ready) begin
                    state_nxt = ST_SENT;
                end
            end
            ST_SENT: begin
                // uart_tx may still show ready for this one cycle, so
                // i_tx_ready is deliberately ignored here.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant capture. Reset clears the held byte, which means a byte caught
    // mid-operation is dropped and not retransmitted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hold      <= '0;
            burst     <= 4'd0;
            last_prot <= 1'b0;
        end else if (load) begin
            hold      <= grant_prot ? i_prot_dat : i_slv_dat;
            burst     <= next_burst(grant_fav, oth_valid, burst);
            last_prot <= grant_prot;
        end
    end

    assign o_slv_ready  = slv_ready;
    assign o_prot_ready = prot_ready;
    assign o_tx_start   = tx_start;
    assign o_tx_dat     = hold;
    assign o_last_prot  = last_prot;
    assign o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Runs two schedulers side by side from the same two byte sources:
//   dut0  S favoured (PREF_PROT = 0)
//   dut1  P favoured (PREF_PROT = 1)
//
// Each scheduler pops the shared sources through its own read pointers.
//
// Every cycle, the outputs are compared with a behavioural model that
// expresses the scheduling rules directly. The model tracks:
//   - whether a byte is held
//   - how many cycles remain before the next pick
//   - the burst count
//   - the last grant source
//
// Directed tests pin the model with hand-computed literal expectations.
//
// A small uart_tx stand-in drops ready for two cycles after each start
// pulse. It can also be held not-ready to stall the transmitter.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      sv, pv, txr;
    logic [1:0][7:0] sd, pd;
    wire  [1:0]      sr, pr, st, bz, lp;
    wire  [1:0][7:0] td;

    uart_tx_sched #(.DATA_W(8), .MAX_BURST(4), .PREF_PROT(1'b0)) dut0 (
        .i_clk(clk), .i_reset(rst),
        .i_slv_valid(sv[0]), .i_slv_dat(sd[0]), .o_slv_ready(sr[0]),
        .i_prot_valid(pv[0]), .i_prot_dat(pd[0]), .o_prot_ready(pr[0]),
        .o_tx_dat(td[0]), .o_tx_start(st[0]), .i_tx_ready(txr[0]),
        .o_last_prot(lp[0]), .o_busy(bz[0])
    );

    uart_tx_sched #(.DATA_W(8), .MAX_BURST(4), .PREF_PROT(1'b1)) dut1 (
        .i_clk(clk), .i_reset(rst),
        .i_slv_valid(sv[1]), .i_slv_dat(sd[1]), .o_slv_ready(sr[1]),
        .i_prot_valid(pv[1]), .i_prot_dat(pd[1]), .o_prot_ready(pr[1]),
        .o_tx_dat(td[1]), .o_tx_start(st[1]), .i_tx_ready(txr[1]),
        .o_last_prot(lp[1]), .o_busy(bz[1])
    );

    // Byte sources shared by both schedulers
    logic [7:0] s_mem [64];
    logic [7:0] p_mem [64];
    int s_n, p_n;
    int sp [2];
    int pp [2];

    // Behavioural model, current and planned
    bit         m_loaded [2];
    int         m_cool   [2];
    logic [7:0] m_hold   [2];
    int         m_burst  [2];
    bit         m_last   [2];
    bit         n_loaded [2];
    int         n_cool   [2];
    logic [7:0] n_hold   [2];
    int         n_burst  [2];
    bit         n_last   [2];
    bit         pop_s [2];
    bit         pop_p [2];
    bit         started [2];

    // uart_tx stand-in
    int tx_cnt [2];
    bit tx_hold;

    // Observed grants (0 = S, 1 = P) and transmitted bytes per scheduler
    int         glog [2][64];
    int         gn   [2];
    logic [7:0] tlog [2][64];
    int         tn   [2];

    // Outputs captured at the most recent compare point
    logic [1:0]      sn_sr, sn_pr, sn_st, sn_bz;
    logic [1:0][7:0] sn_td;

    int checks, errors;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            sv[k] = (sp[k] < s_n);
            pv[k] = (pp[k] < p_n);
            sd[k] = sv[k] ? s_mem[sp[k]] : 8'h00;
            pd[k] = pv[k] ? p_mem[pp[k]] : 8'h00;
        end
    endtask

    task automatic push_s(input logic [7:0] b);
        s_mem[s_n] = b;
        s_n++;
    endtask

    task automatic push_p(input logic [7:0] b);
        p_mem[p_n] = b;
        p_n++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_loaded[k] = 0; m_cool[k] = 0; m_hold[k] = 8'h00;
            m_burst[k]  = 0; m_last[k] = 0; tx_cnt[k] = 0;
        end
    endtask

    // Compare the DUT with the model and plan the model's next step.
    task automatic check_plan(input int k);
        bit svk, pvk, free, favp, fv, nv, gf, gp, grant;
        logic [7:0] sdk, pdk;

        svk  = (sp[k] < s_n);
        pvk  = (pp[k] < p_n);
        sdk  = svk ? s_mem[sp[k]] : 8'h00;
        pdk  = pvk ? p_mem[pp[k]] : 8'h00;
        free = !m_loaded[k] && (m_cool[k] == 0);
        favp = (k == 1);
        fv   = favp ? pvk : svk;
        nv   = favp ? svk : pvk;

        if (svk && pvk) gf = (m_burst[k] != 4);
        else            gf = fv;
        gp    = gf ? favp : !favp;
        grant = free && (svk || pvk) && !rst;

        chk("slv_ready",  k, sr[k], grant && !gp);
        chk("prot_ready", k, pr[k], grant && gp);
        chk("tx_start",   k, st[k], !rst && m_loaded[k] && txr[k]);
        chk("tx_dat",     k, td[k], m_hold[k]);
        chk("busy",       k, bz[k], !free);
        chk("last_prot",  k, lp[k], m_last[k]);

        sn_sr[k] = sr[k]; sn_pr[k] = pr[k]; sn_st[k] = st[k];
        sn_bz[k] = bz[k]; sn_td[k] = td[k];
        if (sr[k] && gn[k] < 64) begin glog[k][gn[k]] = 0; gn[k]++; end
        if (pr[k] && gn[k] < 64) begin glog[k][gn[k]] = 1; gn[k]++; end
        if (st[k] && tn[k] < 64) begin tlog[k][tn[k]] = td[k]; tn[k]++; end

        n_loaded[k] = m_loaded[k]; n_cool[k] = m_cool[k]; n_hold[k] = m_hold[k];
        n_burst[k]  = m_burst[k];  n_last[k] = m_last[k];
        pop_s[k] = 0; pop_p[k] = 0; started[k] = 0;

        if (grant) begin
            n_hold[k]   = gp ? pdk : sdk;
            n_loaded[k] = 1;
            n_last[k]   = gp;
            n_burst[k]  = (gf && nv) ? m_burst[k] + 1 : 0;
            pop_p[k]    = gp;
            pop_s[k]    = !gp;
        end else if (!rst && m_loaded[k] && txr[k]) begin
            n_loaded[k] = 0;
            n_cool[k]   = 1;
            started[k]  = 1;
        end else if (m_cool[k] > 0) begin
            n_cool[k] = m_cool[k] - 1;
        end
    endtask

    task automatic commit(input int k);
        m_loaded[k] = n_loaded[k]; m_cool[k] = n_cool[k]; m_hold[k] = n_hold[k];
        m_burst[k]  = n_burst[k];  m_last[k] = n_last[k];
        if (pop_s[k]) sp[k]++;
        if (pop_p[k]) pp[k]++;
        if (started[k]) tx_cnt[k] = 2;
        if (tx_hold) begin
            txr[k] = 1'b0;
        end else if (tx_cnt[k] > 0) begin
            txr[k] = 1'b0;
            tx_cnt[k]--;
        end else begin
            txr[k] = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_plan(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) commit(k);
        drive();
    endtask

    task automatic drain(input string nm, input int bound);
        bit done;
        done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            done = 1;
            for (int k = 0; k < 2; k++)
                if (sp[k] != s_n || pp[k] != p_n || m_loaded[k] || m_cool[k] != 0) done = 0;
            if (!done) cycle();
        end
        chk(nm, 0, done, 1);
    endtask

    int g0, g1, t0, t1, es, ep;
    int e_b0 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int e_b1 [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [7:0] e_t5 [8] = '{8'hC0, 8'hC1, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};

    initial begin
        checks = 0; errors = 0;
        s_n = 0; p_n = 0; tx_hold = 0;
        for (int k = 0; k < 2; k++) begin
            sp[k] = 0; pp[k] = 0; gn[k] = 0; tn[k] = 0;
        end
        model_reset();
        txr = 2'b11;
        rst = 1'b1;
        drive();

        // Power-on reset
        repeat (3) cycle();
        for (int k = 0; k < 2; k++) begin
            chk("por_busy", k, sn_bz[k], 0);
            chk("por_dat",  k, sn_td[k], 8'h00);
            chk("por_start", k, sn_st[k], 0);
        end
        rst = 1'b0;
        cycle();

        // Reset while a byte is parked: 0xA5 loaded, transmitter stalled
        tx_hold = 1; txr = 2'b00;
        push_s(8'hA5); drive();
        cycle();
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("rst_pre_dat",   k, sn_td[k], 8'hA5);
            chk("rst_pre_start", k, sn_st[k], 0);
        end
        tx_hold = 0; txr = 2'b11;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_start_now", k, st[k], 0);
            chk("rst_dat_now",   k, td[k], 8'h00);
            chk("rst_busy_now",  k, bz[k], 0);
        end
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;
        t0 = tn[0]; t1 = tn[1];
        repeat (5) cycle();
        chk("rst_no_restart", 0, tn[0], t0);
        chk("rst_no_restart", 1, tn[1], t1);

        // Single S byte 0x41 with uart_tx ready
        push_s(8'h41); drive();
        cycle();
        for (int k = 0; k < 2; k++) chk("single_T_ready", k, sn_sr[k], 1);
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("single_T1_start", k, sn_st[k], 1);
            chk("single_T1_dat",   k, sn_td[k], 8'h41);
        end
        cycle();
        for (int k = 0; k < 2; k++) chk("single_T2_busy", k, sn_bz[k], 1);
        cycle();
        for (int k = 0; k < 2; k++) chk("single_T3_idle", k, sn_bz[k], 0);

        // Stalled transmitter for 10 cycles, then released
        tx_hold = 1; txr = 2'b00;
        push_s(8'h5A); drive();
        cycle();
        repeat (10) begin
            cycle();
            chk("stall_no_start", 0, sn_st[0], 0);
            chk("stall_dat",      0, sn_td[0], 8'h5A);
        end
        tx_hold = 0; txr = 2'b11;
        cycle();
        for (int k = 0; k < 2; k++) chk("stall_release_start", k, sn_st[k], 1);
        drain("stall_drain", 20);

        // Both valids rise in the same idle cycle
        g0 = gn[0]; g1 = gn[1]; t0 = tn[0]; t1 = tn[1];
        push_s(8'h61); push_p(8'h62); drive();
        cycle();
        chk("simul_s_ready", 0, sn_sr[0], 1);
        chk("simul_p_ready", 0, sn_pr[0], 0);
        chk("simul_s_ready", 1, sn_sr[1], 0);
        chk("simul_p_ready", 1, sn_pr[1], 1);
        drain("simul_drain", 30);
        chk("simul_count", 0, tn[0] - t0, 2);
        chk("simul_count", 1, tn[1] - t1, 2);
        chk("simul_second", 0, tlog[0][t0 + 1], 8'h62);
        chk("simul_second", 1, tlog[1][t1 + 1], 8'h61);

        // Burst limit with both requesters continuously valid
        g0 = gn[0]; g1 = gn[1]; t0 = tn[0];
        for (int i = 0; i < 10; i++) begin
            push_s(8'h10 + 8'(i));
            push_p(8'h80 + 8'(i));
        end
        drive();
        drain("burst_drain", 400);
        for (int i = 0; i < 10; i++) begin
            chk("burst_seq", 0, glog[0][g0 + i], e_b0[i]);
            chk("burst_seq", 1, glog[1][g1 + i], e_b1[i]);
        end
        chk("burst_first5", 0, tlog[0][t0 + 4], 8'h80);
        chk("burst_first5", 0, tlog[0][t0 + 5], 8'h14);
        chk("burst_total",  0, gn[0] - g0, 20);

        // P holds 2 bytes, S holds 6; dut1 favours P
        g1 = gn[1]; t0 = tn[0]; t1 = tn[1];
        push_p(8'hC0); push_p(8'hC1);
        for (int i = 0; i < 6; i++) push_s(8'h30 + 8'(i));
        drive();
        drain("order_drain", 200);
        chk("order_count", 1, tn[1] - t1, 8);
        for (int i = 0; i < 8; i++) begin
            chk("order_src",  1, glog[1][g1 + i], (i < 2) ? 1 : 0);
            chk("order_byte", 1, tlog[1][t1 + i], e_t5[i]);
        end
        chk("order_count", 0, tn[0] - t0, 8);
        es = 8'h30; ep = 8'hC0;
        for (int i = 0; i < 8; i++) begin
            if (tlog[0][t0 + i] >= 8'h30 && tlog[0][t0 + i] <= 8'h35) begin
                chk("order_s_seq", 0, tlog[0][t0 + i], es);
                es++;
            end else begin
                chk("order_p_seq", 0, tlog[0][t0 + i], ep);
                ep++;
            end
        end
        chk("order_s_all", 0, es, 8'h36);
        chk("order_p_all", 0, ep, 8'hC2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
